// File: rtl/mem_arbiter_nch.sv
// mem_arbiter_nch: round-robin N-channel arbiter serialising 1/2/4-byte accesses onto an 8-bit RAM/IO bus
module mem_arbiter_nch #(
  parameter int NCH = 2,
  parameter int ADDR_W = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [NCH-1:0]        req,
  input  logic [NCH-1:0]        we,
  input  logic [2*NCH-1:0]      len,
  input  logic [ADDR_W*NCH-1:0] addr,
  input  logic [32*NCH-1:0]     wdata,
  input  logic [NCH-1:0]        flush,
  output logic [NCH-1:0]        done,
  output logic [31:0]           rdata,
  output logic                  busy,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_W-1:0]     mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);
  localparam int PW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state, state_n;
  logic [PW-1:0] ptr, ch, gnt, idx;
  logic [ADDR_W-1:0] base;
  logic [2:0] nb, icnt, ccnt, ieff;
  logic [1:0] lg;
  logic [31:0] wbuf, rbuf, rnext;
  logic [NCH-1:0] done_r, elig;
  logic found, was_paused, issue, capt, last, abort, io_stall;
  always_comb begin
    elig = req & ~flush & ~done_r;
    found = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = PW'((int'(ptr) + k) % NCH);
      if (!found && elig[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
    end
  end
  always_comb begin
    lg = len[int'(gnt)*2 +: 2];
    ieff = was_paused ? ccnt : icnt;
    issue = state == READ && ieff < nb;
    capt = state == READ && !was_paused && icnt != ccnt;
    last = capt && ccnt + 3'd1 == nb;
    abort = state == READ && flush[ch];
    io_stall = base[17:16] == 2'b11 && io_buffer_full;
    rnext = rbuf;
    rnext[{ccnt[1:0], 3'b000} +: 8] = mem_din;
    mem_a = state == WRITE ? base + ADDR_W'(icnt) : issue ? base + ADDR_W'(ieff) : '0;
    mem_dout = state == WRITE ? wbuf[{icnt[1:0], 3'b000} +: 8] : '0;
    mem_wr = rdy_in && state == WRITE && !io_stall;
    done = rdy_in ? done_r : '0;
    busy = state != IDLE;
    state_n = !rdy_in ? state
            : state == IDLE ? (found ? (we[gnt] ? WRITE : READ) : IDLE)
            : state == READ ? (abort || last ? IDLE : READ)
            : (mem_wr && icnt + 3'd1 == nb ? IDLE : WRITE);
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr <= '0;
      ch <= '0;
      base <= '0;
      nb <= '0;
      icnt <= '0;
      ccnt <= '0;
      wbuf <= '0;
      rbuf <= '0;
      rdata <= '0;
      done_r <= '0;
      was_paused <= 1'b0;
    end else if (rdy_in) begin
      was_paused <= 1'b0;
      done_r <= '0;
      if (state == IDLE && found) begin
        ch <= gnt;
        ptr <= gnt == PW'(NCH - 1) ? '0 : gnt + 1'b1;
        base <= addr[int'(gnt)*ADDR_W +: ADDR_W];
        nb <= lg == 2'd0 ? 3'd1 : lg == 2'd1 ? 3'd2 : 3'd4;
        wbuf <= wdata[int'(gnt)*32 +: 32];
        icnt <= '0;
        ccnt <= '0;
        rbuf <= '0;
      end
      if (issue) icnt <= ieff + 3'd1;
      if (capt) begin
        ccnt <= ccnt + 3'd1;
        rbuf <= rnext;
      end
      if (last && !abort) begin
        rdata <= rnext;
        done_r <= NCH'(1) << ch;
      end
      if (mem_wr) begin
        icnt <= icnt + 3'd1;
        if (icnt + 3'd1 == nb) done_r <= NCH'(1) << ch;
      end
    end else begin
      was_paused <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter_nch.sv
// tb_mem_arbiter_nch: self-checking bench with vector table, scoreboards and corner-case sequences
module tb_mem_arbiter_nch;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, busy, mem_wr, io_buffer_full;
  logic [1:0] req, we, flush, done;
  logic [3:0] len;
  logic [63:0] addr, wdata;
  logic [31:0] rdata, mem_a;
  logic [7:0] mem_din = 8'h00;
  logic [7:0] mem_dout;
  logic [7:0] ram [0:1023];
  typedef struct {int ch; bit w; logic [1:0] l; logic [31:0] a; logic [31:0] wd; logic [31:0] exp;} vec_t;
  typedef struct {int ch; bit rd; logic [31:0] exp;} sb_t;
  typedef struct {logic [31:0] a; logic [7:0] d;} wr_t;
  vec_t vt [9];
  sb_t sbq [$];
  wr_t wq [$];
  int checks = 0;
  int failures = 0;
  mem_arbiter_nch #(.NCH(2), .ADDR_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .req(req), .we(we), .len(len),
    .addr(addr), .wdata(wdata), .flush(flush), .done(done), .rdata(rdata), .busy(busy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) begin
    mem_din <= ram[mem_a[9:0]];
    if (mem_wr && mem_a[17:16] != 2'b11) ram[mem_a[9:0]] <= mem_dout;
  end
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  always @(negedge clk_in) begin : mon
    wr_t w;
    if (!rst_in) begin
      if (mem_wr) begin
        if (wq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bus_write unexpected a=%0h d=%0h required=none", mem_a, mem_dout);
        end else begin
          w = wq.pop_front();
          chk("bus_write_addr", mem_a, w.a);
          chk("bus_write_data", mem_dout, w.d);
        end
      end
      if (done != 2'b00) chk("done_onehot_notbusy", {$onehot(done), busy}, 2'b10);
    end
  end
  task automatic set_ch(int c, bit w, logic [1:0] l, logic [31:0] a, logic [31:0] d, logic [31:0] exp);
    int n;
    we[c] = w;
    len[2*c +: 2] = l;
    addr[32*c +: 32] = a;
    wdata[32*c +: 32] = d;
    n = l == 2'd0 ? 1 : l == 2'd1 ? 2 : 4;
    if (w) for (int k = 0; k < n; k++) wq.push_back('{a + k, d[8*k +: 8]});
    sbq.push_back('{c, !w, exp});
  endtask
  task automatic finish_done(string nm);
    sb_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s unexpected done=%b required=00", nm, done);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_done"}, done, 64'd1 << e.ch);
      if (e.rd) chk({nm, "_rdata"}, rdata, e.exp);
    end
    req = req & ~done;
  endtask
  task automatic wait_done(string nm, output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (done == 2'b00 && n < 60);
    if (done == 2'b00) begin
      checks++;
      failures++;
      $display("FAIL %s timeout done=%b required=nonzero", nm, done);
    end else finish_done(nm);
  endtask
  initial begin
    int n, guard;
    int cnt [2];
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[0] = 8'h5c;
    ram[10'h100] = 8'h11;
    ram[10'h101] = 8'h22;
    ram[10'h102] = 8'h33;
    ram[10'h103] = 8'h44;
    vt[0] = '{0, 1'b1, 2'd2, 32'h200, 32'hdeadbeef, 32'h0};
    vt[1] = '{1, 1'b0, 2'd2, 32'h200, 32'h0, 32'hdeadbeef};
    vt[2] = '{1, 1'b1, 2'd1, 32'h204, 32'h1234cafe, 32'h0};
    vt[3] = '{0, 1'b0, 2'd0, 32'h205, 32'h0, 32'h000000ca};
    vt[4] = '{0, 1'b0, 2'd1, 32'h204, 32'h0, 32'h0000cafe};
    vt[5] = '{1, 1'b0, 2'd3, 32'h200, 32'h0, 32'hdeadbeef};
    vt[6] = '{0, 1'b1, 2'd0, 32'h3ff, 32'h000000ab, 32'h0};
    vt[7] = '{1, 1'b0, 2'd1, 32'hffffffff, 32'h0, 32'h00005cab};
    vt[8] = '{0, 1'b0, 2'd2, 32'h100, 32'h0, 32'h44332211};
    rst_in = 1'b1;
    rdy_in = 1'b1;
    req = '0;
    we = '0;
    len = '0;
    addr = '0;
    wdata = '0;
    flush = '0;
    io_buffer_full = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("reset_outputs", {done, rdata, busy, mem_a, mem_dout, mem_wr}, '0);
    rst_in = 1'b0;
    set_ch(0, 1'b0, 2'd0, 32'h100, 32'h0, 32'h11);
    set_ch(1, 1'b0, 2'd0, 32'h101, 32'h0, 32'h22);
    sbq.push_back('{0, 1'b1, 32'h11});
    sbq.push_back('{1, 1'b1, 32'h22});
    cnt[0] = 0;
    cnt[1] = 0;
    guard = 0;
    req = 2'b11;
    while (cnt[0] + cnt[1] < 4 && guard < 200) begin
      @(negedge clk_in);
      guard++;
      for (int c = 0; c < 2; c++) begin
        if (done[c]) begin
          finish_done("round_robin");
          cnt[c]++;
        end else if (!req[c] && cnt[c] < 2) req[c] = 1'b1;
      end
    end
    if (guard >= 200) begin
      checks++;
      failures++;
      $display("FAIL round_robin timeout served=%0d required=4", cnt[0] + cnt[1]);
    end
    for (int i = 0; i < 9; i++) begin
      set_ch(vt[i].ch, vt[i].w, vt[i].l, vt[i].a, vt[i].wd, vt[i].exp);
      req[vt[i].ch] = 1'b1;
      wait_done($sformatf("vec%0d", i), n);
    end
    @(negedge clk_in);
    set_ch(1, 1'b0, 2'd2, 32'h100, 32'h0, 32'h44332211);
    req[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      chk($sformatf("read_timing_addr%0d", k), mem_a, 32'h100 + k);
    end
    @(negedge clk_in);
    chk("read_timing_no_early_done", done, 2'b00);
    @(negedge clk_in);
    finish_done("read_timing");
    @(negedge clk_in);
    set_ch(1, 1'b0, 2'd2, 32'h100, 32'h0, 32'h44332211);
    req[1] = 1'b1;
    repeat (2) @(negedge clk_in);
    rdy_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rdy_in = 1'b1;
    wait_done("pause_read", n);
    chk("pause_delay", n + 4 >= 8, 1);
    @(negedge clk_in);
    io_buffer_full = 1'b1;
    set_ch(0, 1'b1, 2'd0, 32'h30000, 32'h77, 32'h0);
    req[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk_in);
      chk($sformatf("io_stall%0d", k), {busy, mem_wr}, 2'b10);
    end
    @(posedge clk_in);
    #1 io_buffer_full = 1'b0;
    @(negedge clk_in);
    chk("io_resume_write", mem_wr, 1'b1);
    wait_done("io_write", n);
    @(negedge clk_in);
    set_ch(0, 1'b0, 2'd2, 32'h100, 32'h0, 32'h0);
    void'(sbq.pop_back());
    req[0] = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    req = '0;
    @(negedge clk_in);
    chk("mid_reset_idle", {done, busy, mem_wr, mem_a}, '0);
    rst_in = 1'b0;
    @(negedge clk_in);
    set_ch(1, 1'b0, 2'd1, 32'h204, 32'h0, 32'h0);
    void'(sbq.pop_back());
    req[1] = 1'b1;
    @(negedge clk_in);
    chk("flush_busy_before", busy, 1'b1);
    flush = 2'b10;
    req[1] = 1'b0;
    set_ch(0, 1'b0, 2'd0, 32'h205, 32'h0, 32'h000000ca);
    req[0] = 1'b1;
    @(negedge clk_in);
    chk("flush_idle_no_done", {busy, done}, 3'b000);
    flush = 2'b00;
    @(negedge clk_in);
    chk("flush_next_grant", busy, 1'b1);
    wait_done("after_flush", n);
    repeat (3) @(negedge clk_in);
    chk("scoreboards_empty", {wq.size(), sbq.size()}, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
